// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encoding and default widths for the program loader.
// Rev 1.0
`default_nettype none

package prog_loader_pkg;

    localparam int ADDR_W_DEFAULT = 10;
    localparam int DATA_W_DEFAULT = 18;
    localparam int LEN_W          = 10;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LEN_HI = 4'd1,
        ST_LEN_LO = 4'd2,
        ST_B0     = 4'd3,
        ST_B1     = 4'd4,
        ST_B2     = 4'd5,
        ST_WRITE  = 4'd6,
        ST_CSUM   = 4'd7,
        ST_FIN    = 4'd8
    } state_e;

    // States in which a serial byte may be consumed.
    function automatic logic accepts_byte(input state_e s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_B0) ||
               (s == ST_B1) || (s == ST_B2) || (s == ST_CSUM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed, checksummed byte stream and writes 18-bit words to program memory.
// Rev 1.0
`default_nettype none

module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              LOAD_START,
    input  logic [7:0]        BYTE_IN,
    input  logic              BYTE_VALID,
    output logic              BYTE_READY,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_DATA,
    output logic              CPU_HOLD,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [7:0]          csum_q, csum_d;
    logic [1:0]          b0_q, b0_d;
    logic [7:0]          b1_q, b1_d;
    logic                err_q, err_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                ready_q, busy_q, done_q;
    logic                byte_take;

    // ready_q always reflects state_q, so this is the handshake for the current state.
    assign byte_take = BYTE_VALID && ready_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (LOAD_START) begin
                    state_d = ST_LEN_HI;
                    err_d   = 1'b0;
                    len_d   = '0;
                    idx_d   = '0;
                    csum_d  = '0;
                end
            end
            ST_LEN_HI: begin
                if (byte_take) begin
                    len_d   = {BYTE_IN[1:0], len_q[7:0]};
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (byte_take) begin
                    len_d   = {len_q[9:8], BYTE_IN};
                    state_d = ST_B0;
                end
            end
            ST_B0: begin
                if (byte_take) begin
                    b0_d    = BYTE_IN[1:0];
                    csum_d  = csum_q ^ BYTE_IN;
                    state_d = ST_B1;
                end
            end
            ST_B1: begin
                if (byte_take) begin
                    b1_d    = BYTE_IN;
                    csum_d  = csum_q ^ BYTE_IN;
                    state_d = ST_B2;
                end
            end
            ST_B2: begin
                if (byte_take) begin
                    csum_d  = csum_q ^ BYTE_IN;
                    we_d    = 1'b1;
                    addr_d  = idx_q;
                    data_d  = DATA_W'({b0_q, b1_q, BYTE_IN});
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                idx_d   = idx_q + 1'b1;
                state_d = (idx_q == ADDR_W'(len_q)) ? ST_CSUM : ST_B0;
            end
            ST_CSUM: begin
                if (byte_take) begin
                    err_d   = err_q | (BYTE_IN != csum_q);
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
            b0_q    <= '0;
            b1_q    <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            // Status outputs are decoded from the next state so they align with state_q.
            ready_q <= accepts_byte(state_d);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_FIN) && !err_d;
        end
    end

    assign BYTE_READY = ready_q;
    assign MEM_WE     = we_q;
    assign MEM_ADDR   = addr_q;
    assign MEM_DATA   = data_q;
    assign BUSY       = busy_q;
    assign CPU_HOLD   = busy_q;
    assign DONE       = done_q;
    assign ERR        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized scoreboard bench for prog_loader.
// Rev 1.0
`default_nettype none

module tb_prog_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        LOAD_START = 1'b0;
    logic [7:0]  BYTE_IN = 8'h00;
    logic        BYTE_VALID = 1'b0;
    logic        BYTE_READY, MEM_WE, CPU_HOLD, BUSY, DONE, ERR;
    logic [9:0]  MEM_ADDR;
    logic [17:0] MEM_DATA;

    prog_loader #(.ADDR_W(10), .DATA_W(18)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .LOAD_START (LOAD_START),
        .BYTE_IN    (BYTE_IN),
        .BYTE_VALID (BYTE_VALID),
        .BYTE_READY (BYTE_READY),
        .MEM_WE     (MEM_WE),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_DATA   (MEM_DATA),
        .CPU_HOLD   (CPU_HOLD),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ERR        (ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          addr;
        logic [17:0] data;
    } wr_t;

    int          n_vec = 0;
    int          n_mis = 0;
    wr_t         exp_wr[$];
    int          exp_done = 0;
    logic [17:0] dir_words[$];
    int          cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected writes / DONE pulses whenever the DUT presents them.
    logic [9:0]  last_addr = '0;
    logic [17:0] last_data = '0;
    bit          prev_ok = 1'b0;
    wr_t         e;
    always @(negedge CLK) begin
        if (MEM_WE) begin
            if (exp_wr.size() == 0) begin
                n_vec++;
                n_mis++;
                $display("FAIL unexpected_write: addr %0h data %0h, expected no write", MEM_ADDR, MEM_DATA);
            end else begin
                e = exp_wr.pop_front();
                chk("wr_addr", 32'(MEM_ADDR), 32'(e.addr));
                chk("wr_data", 32'(MEM_DATA), 32'(e.data));
            end
        end else if (prev_ok && !RST) begin
            chk("hold_addr", 32'(MEM_ADDR), 32'(last_addr));
            chk("hold_data", 32'(MEM_DATA), 32'(last_data));
        end
        if (DONE) begin
            if (exp_done == 0) begin
                n_vec++;
                n_mis++;
                $display("FAIL unexpected_done: DONE=1, expected 0");
            end else begin
                exp_done--;
            end
        end
        prev_ok   = !RST;
        last_addr = MEM_ADDR;
        last_data = MEM_DATA;
    end

    // One byte handshake; valid is randomly withheld unless fast is set.
    task automatic send_byte(input logic [7:0] b, input bit fast, input bit poke);
        int waited = 0;
        bit got = 1'b0;
        while (!got && waited < 400) begin
            BYTE_VALID = fast ? 1'b1 : ($urandom_range(0, 3) != 0);
            BYTE_IN    = BYTE_VALID ? b : 8'($urandom);
            LOAD_START = poke && ($urandom_range(0, 7) == 0);
            @(negedge CLK);
            got = BYTE_VALID && BYTE_READY;
            @(posedge CLK);
            #1;
            waited++;
        end
        BYTE_VALID = 1'b0;
        LOAD_START = 1'b0;
        if (!got) begin
            n_vec++;
            n_mis++;
            $display("FAIL byte_timeout: byte %0h not accepted, expected acceptance within 400 cycles", b);
        end
    endtask

    task automatic start_load();
        LOAD_START = 1'b1;
        @(posedge CLK);
        #1;
        LOAD_START = 1'b0;
        chk("err_cleared", 32'(ERR), 0);
        chk("busy_on", 32'(BUSY), 1);
        chk("hold_on", 32'(CPU_HOLD), 1);
    endtask

    // Reference model: word i goes to address i; checksum is XOR of every data byte.
    task automatic do_load(input int len, input bit bad, input bit fast, input bit poke);
        logic [7:0]  cs = 8'h00;
        logic [7:0]  b0, b1, b2, csb;
        logic [17:0] w;
        logic [9:0]  l = 10'(len);
        bit          directed = (dir_words.size() != 0);
        int          t0;
        start_load();
        send_byte({directed ? 6'd0 : 6'($urandom), l[9:8]}, fast, 1'b0);
        send_byte(l[7:0], fast, 1'b0);
        t0 = cyc;
        for (int i = 0; i <= len; i++) begin
            w  = directed ? dir_words[i] : 18'($urandom);
            b0 = {directed ? 6'd0 : 6'($urandom), w[17:16]};
            b1 = w[15:8];
            b2 = w[7:0];
            cs = cs ^ b0 ^ b1 ^ b2;
            exp_wr.push_back('{i, w});
            send_byte(b0, fast, poke);
            send_byte(b1, fast, poke);
            send_byte(b2, fast, poke);
        end
        if (fast)
            chk("throughput", 32'((cyc - t0) <= 4 * (len + 1) + 2), 1);
        csb = bad ? (directed ? 8'h00 : cs ^ 8'($urandom_range(1, 255))) : cs;
        if (!bad) exp_done++;
        send_byte(csb, fast, poke);
        repeat (3) @(posedge CLK);
        #1;
        chk("err_final", 32'(ERR), 32'(bad));
        chk("idle_busy", 32'(BUSY), 0);
        chk("idle_hold", 32'(CPU_HOLD), 0);
        chk("idle_ready", 32'(BYTE_READY), 0);
        chk("writes_drained", 32'(exp_wr.size()), 0);
        chk("done_seen", 32'(exp_done), 0);
        dir_words.delete();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ready", 32'(BYTE_READY), 0);
        chk("rst_we", 32'(MEM_WE), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_hold", 32'(CPU_HOLD), 0);
        chk("rst_done", 32'(DONE), 0);
        chk("rst_err", 32'(ERR), 0);
        chk("rst_addr", 32'(MEM_ADDR), 0);
        chk("rst_data", 32'(MEM_DATA), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] w;
        // Reset with a simultaneous LOAD_START: reset must win.
        repeat (2) @(posedge CLK);
        LOAD_START = 1'b1;
        @(posedge CLK);
        #1;
        chk_reset_outputs();
        RST = 1'b0;
        LOAD_START = 1'b0;
        @(posedge CLK);
        #1;
        chk("rst_beats_start", 32'(BUSY), 0);

        // Single word 0x31234, checksum 0x25.
        dir_words.push_back(18'h31234);
        do_load(0, 1'b0, 1'b0, 1'b0);

        // Two words at the data-range extremes.
        dir_words.push_back(18'h3FFFF);
        dir_words.push_back(18'h00001);
        do_load(1, 1'b0, 1'b0, 1'b0);

        // Same single word with checksum 0x00: write kept, ERR sticky, no DONE.
        dir_words.push_back(18'h31234);
        do_load(0, 1'b1, 1'b0, 1'b0);
        repeat (5) @(posedge CLK);
        #1;
        chk("err_sticky", 32'(ERR), 1);

        // Full 1024-word image with valid held high.
        do_load(1023, 1'b0, 1'b1, 1'b0);

        // Randomized loads with valid toggling and stray LOAD_START pulses.
        for (int k = 0; k < 8; k++)
            do_load($urandom_range(0, 12), ($urandom_range(0, 3) == 0), 1'b0, 1'b1);

        // Reset after the B1 byte of word 5.
        start_load();
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h09, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            w = 18'($urandom);
            exp_wr.push_back('{i, w});
            send_byte({6'd0, w[17:16]}, 1'b0, 1'b0);
            send_byte(w[15:8], 1'b0, 1'b0);
            send_byte(w[7:0], 1'b0, 1'b0);
        end
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'hAB, 1'b0, 1'b0);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk_reset_outputs();
        RST = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        chk("abort_busy", 32'(BUSY), 0);
        chk("abort_writes", 32'(exp_wr.size()), 0);
        chk("abort_done", 32'(exp_done), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 10, program memory address width (1024 words).
REQ-002 Parameter DATA_W, default 18, instruction word width.
REQ-003 CLK  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 RST  input  1  reset; synchronous, active-high.
REQ-005 LOAD_START  input  1  single-cycle request to begin a program load.
REQ-006 BYTE_IN  input  8  serial-link byte.
REQ-007 BYTE_VALID  input  1  BYTE_IN holds a byte.
REQ-008 BYTE_READY  output  1  loader will accept BYTE_IN this cycle.
REQ-009 MEM_WE  output  1  program memory write strobe.
REQ-010 MEM_ADDR  output  ADDR_W  program memory write address.
REQ-011 MEM_DATA  output  DATA_W  program memory write data.
REQ-012 CPU_HOLD  output  1  holds the MCU in reset while high.
REQ-013 BUSY  output  1  load in progress.
REQ-014 DONE  output  1  one-cycle pulse on successful load.
REQ-015 ERR  output  1  sticky checksum-failure flag.

Function
REQ-016 A byte SHALL transfer only on a cycle where BYTE_VALID and BYTE_READY are both high.
REQ-017 FSM states SHALL be IDLE, LEN_HI, LEN_LO, B0, B1, B2, WRITE, CSUM, FIN.
REQ-018 IDLE: LOAD_START SHALL move to LEN_HI and clear ERR; LOAD_START in any other state SHALL be ignored.
REQ-019 LEN_HI: the accepted byte's bits[1:0] SHALL form LEN[9:8]; bits[7:2] are ignored. LEN_LO: the accepted byte SHALL form LEN[7:0]. Word count = LEN+1 (1..1024).
REQ-020 B0 bits[1:0] -> word[17:16], B1 -> word[15:8], B2 -> word[7:0]; B0 bits[7:2] are ignored.
REQ-021 The cycle after the B2 byte is accepted, state SHALL be WRITE, asserting MEM_WE for exactly one cycle with MEM_ADDR = word index and MEM_DATA = assembled word.
REQ-022 Word index SHALL start at 0 and increment after each WRITE. After WRITE: index == LEN -> CSUM, else -> B0.
REQ-023 Checksum SHALL be the 8-bit XOR of every accepted B0/B1/B2 byte (all 8 bits); length bytes are excluded.
REQ-024 CSUM: on byte acceptance, state SHALL go to FIN; ERR SHALL be set if the byte differs from the checksum.
REQ-025 FIN SHALL last one cycle, pulse DONE when ERR is low, then return to IDLE.
REQ-026 BYTE_READY SHALL be high only in LEN_HI, LEN_LO, B0, B1, B2 and CSUM; low in IDLE, WRITE and FIN.
REQ-027 BUSY and CPU_HOLD SHALL be high in every state except IDLE.
REQ-028 Words already written SHALL NOT be retracted on checksum failure.
REQ-029 Minimum throughput SHALL be one word per 4 cycles with BYTE_VALID held high.
REQ-030 MEM_ADDR and MEM_DATA SHALL hold their last values when MEM_WE is low.
REQ-031 A stalled BYTE_VALID SHALL hold the current state indefinitely; there is no timeout.

Reset
REQ-032 RST SHALL force IDLE, word index 0, checksum 0 and LEN 0.
REQ-033 RST SHALL force MEM_WE, BUSY, CPU_HOLD, DONE, ERR and BYTE_READY low, and MEM_ADDR and MEM_DATA to 0.
REQ-034 RST mid-load SHALL abort the load with no further writes and no DONE.
REQ-035 RST SHALL take priority over LOAD_START in the same cycle.

Structure
REQ-036 Package prog_loader_pkg SHALL hold the FSM state enum and the ADDR_W/DATA_W defaults.
REQ-037 No sub-module is required; word assembly and checksum SHALL be inline.

Verification
REQ-038 LOAD_START; bytes 00,00,03,12,34,25 -> one write, addr 0, data 0x31234; DONE pulses; ERR = 0.
REQ-039 LEN = 0x001; words 0x3FFFF and 0x00001 with correct checksum -> writes at addr 0 and 1; DONE pulses.
REQ-040 Same stream as REQ-038 with checksum byte 0x00 -> write still occurs; ERR = 1; no DONE; ERR clears on the next LOAD_START.
REQ-041 LEN bytes 03,FF with 1024 words streamed -> last write at addr 0x3FF; CSUM follows; no address wrap.
REQ-042 RST asserted after the B1 byte of word 5 -> no write at addr 5; all outputs return to reset values the next cycle.
REQ-043 BYTE_VALID toggled randomly; LOAD_START pulsed while BUSY -> no byte lost or duplicated; the second LOAD_START is ignored.
